iprf_wb_arbiter: RTL and testbench

- Arbitrates integer-physical-regfile write requests from REQ_NUM functional-unit writeback sources onto WPORT_NUM regfile write ports.
- Sits between the FU writeback outputs of the integer/memory blocks and the write ports of the integer physical regfile. It replaces the fixed one-FU-per-port wiring.
- Policy is round-robin with a starvation override. Write-port outputs are registered.

---
 rtl/iprf_wb_arbiter_pkg.sv | 21 ++
 rtl/iprf_wb_rr_select.sv | 43 ++++
 rtl/iprf_wb_arbiter.sv | 150 +++++++++++++++
 tb/tb_iprf_wb_arbiter.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/iprf_wb_arbiter_pkg.sv
// Shared types and constants for the integer physical regfile writeback arbiter.
// Provides the physical register index type, the writeback request struct and
// a small modular-add helper used for round-robin pointer arithmetic.
package iprf_wb_arbiter_pkg;
  localparam int XLEN            = 64;
  localparam int IPHYREG_NUM     = 128;
  localparam int IPRF_WBPORT_NUM = 6;
  localparam int IPR_IDX_W       = $clog2(IPHYREG_NUM);

  typedef logic [IPR_IDX_W-1:0] iprIdx_t;

  typedef struct packed {
    iprIdx_t         iprd_idx;
    logic [XLEN-1:0] data;
  } iprfWbReq_t;

  // (a + b) mod n, for pointer wrap on non-power-of-two requester counts
  function automatic int unsigned wrap_add(int unsigned a, int unsigned b, int unsigned n);
    return (a + b) % n;
  endfunction
endpackage

// File: rtl/iprf_wb_rr_select.sv
// Combinational round-robin picker.
// Scans requesters from 'start' upward (wrapping), skipping 'excl', and grants
// up to 'ports' of them. Slot k of 'sel' holds the k-th granted requester.
//   req   : candidate request mask
//   excl  : requesters already granted elsewhere
//   start : scan start index
//   ports : number of grants allowed
//   gnt   : grant mask
//   sel   : per-slot requester index, valid for slots < cnt
//   cnt   : number of grants issued
module iprf_wb_rr_select
  import iprf_wb_arbiter_pkg::*;
#(
  parameter int REQ_NUM   = 8,
  parameter int WPORT_NUM = 6,
  parameter int PTR_W     = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1,
  parameter int CNT_W     = $clog2(WPORT_NUM + 1)
) (
  input  logic [REQ_NUM-1:0]              req,
  input  logic [REQ_NUM-1:0]              excl,
  input  logic [PTR_W-1:0]                start,
  input  logic [CNT_W-1:0]                ports,
  output logic [REQ_NUM-1:0]              gnt,
  output logic [WPORT_NUM-1:0][PTR_W-1:0] sel,
  output logic [CNT_W-1:0]                cnt
);
  logic [PTR_W-1:0] i;

  always_comb begin
    gnt = '0;
    sel = '0;
    cnt = '0;
    i   = '0;
    for (int k = 0; k < REQ_NUM; k++) begin
      i = PTR_W'(wrap_add(32'(start), k, REQ_NUM));
      if (req[i] && !excl[i] && (cnt < ports)) begin
        gnt[i]   = 1'b1;
        sel[cnt] = i;
        cnt      = cnt + 1'b1;
      end
    end
  end
endmodule

// File: rtl/iprf_wb_arbiter.sv
// Integer physical regfile writeback arbiter.
// Maps REQ_NUM FU writeback requests onto WPORT_NUM registered write ports.
// Starved requesters (wait counter saturated) go first in ascending index
// order, remaining ports are filled round-robin from rr_ptr.
// Ports:
//   clk, rst (async, active-low)
//   i_stall                          : block all grants this cycle
//   i_req_vld/iprIdx/data            : per-requester writeback request
//   o_req_gnt                        : same-cycle combinational accept
//   o_wr_vld/iprIdx/data             : registered write ports (grant + 1 cycle)
//   o_perf_conflict_cnt/starve_cnt   : only with IPRF_WB_ARB_PERF_EN defined
module iprf_wb_arbiter
  import iprf_wb_arbiter_pkg::*;
#(
  parameter int REQ_NUM      = 8,
  parameter int WPORT_NUM    = IPRF_WBPORT_NUM,
  parameter int IDX_W        = IPR_IDX_W,
  parameter int DATA_W       = XLEN,
  parameter int STARVE_LIMIT = 4,
  parameter int HAS_ZERO     = 1
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              i_stall,
  input  logic [REQ_NUM-1:0]                i_req_vld,
  input  logic [REQ_NUM-1:0][IDX_W-1:0]     i_req_iprIdx,
  input  logic [REQ_NUM-1:0][DATA_W-1:0]    i_req_data,
  output logic [REQ_NUM-1:0]                o_req_gnt,
  output logic [WPORT_NUM-1:0]              o_wr_vld,
  output logic [WPORT_NUM-1:0][IDX_W-1:0]   o_wr_iprIdx,
  output logic [WPORT_NUM-1:0][DATA_W-1:0]  o_wr_data
`ifdef IPRF_WB_ARB_PERF_EN
  ,
  output logic [31:0]                       o_perf_conflict_cnt,
  output logic [31:0]                       o_perf_starve_cnt
`endif
);
  localparam int PTR_W = (REQ_NUM > 1) ? $clog2(REQ_NUM) : 1;
  localparam int CNT_W = $clog2(WPORT_NUM + 1);
  localparam int WC_W  = $clog2(STARVE_LIMIT + 1);

  logic [PTR_W-1:0]              rr_ptr;
  logic [REQ_NUM-1:0][WC_W-1:0]  wait_cnt;
  logic [REQ_NUM-1:0]            starved;
  logic [REQ_NUM-1:0]            s_gnt, n_gnt, gnt_raw;
  logic [WPORT_NUM-1:0][PTR_W-1:0] s_sel, n_sel, port_sel;
  logic [CNT_W-1:0]              s_cnt, n_cnt;
  logic [WPORT_NUM-1:0]          port_vld, wr_en;
  logic [PTR_W-1:0]              n_last;

  always_comb begin
    starved = '0;
    for (int i = 0; i < REQ_NUM; i++)
      starved[i] = i_req_vld[i] && (wait_cnt[i] == WC_W'(STARVE_LIMIT));
  end

  // Starved pass: fixed ascending order, may take every port.
  iprf_wb_rr_select #(.REQ_NUM(REQ_NUM), .WPORT_NUM(WPORT_NUM)) u_starve (
    .req(starved), .excl('0), .start('0), .ports(CNT_W'(WPORT_NUM)),
    .gnt(s_gnt), .sel(s_sel), .cnt(s_cnt)
  );

  // Normal pass: round-robin over what the starved pass left.
  iprf_wb_rr_select #(.REQ_NUM(REQ_NUM), .WPORT_NUM(WPORT_NUM)) u_norm (
    .req(i_req_vld), .excl(s_gnt), .start(rr_ptr), .ports(CNT_W'(WPORT_NUM) - s_cnt),
    .gnt(n_gnt), .sel(n_sel), .cnt(n_cnt)
  );

  assign gnt_raw   = s_gnt | n_gnt;
  // Gated by reset so nothing is accepted while outputs are held clear.
  assign o_req_gnt = (rst && !i_stall) ? gnt_raw : '0;
  assign n_last    = n_sel[n_cnt - 1'b1];

  // Starved grants occupy the low ports, normal grants follow.
  always_comb begin
    port_vld = '0;
    port_sel = '0;
    wr_en    = '0;
    for (int p = 0; p < WPORT_NUM; p++) begin
      if (CNT_W'(p) < s_cnt) begin
        port_vld[p] = 1'b1;
        port_sel[p] = s_sel[p];
      end else if ((CNT_W'(p) - s_cnt) < n_cnt) begin
        port_vld[p] = 1'b1;
        port_sel[p] = n_sel[CNT_W'(p) - s_cnt];
      end
      // A zero-register write still burns its port slot but never writes.
      wr_en[p] = port_vld[p] &&
                 !((HAS_ZERO != 0) && (i_req_iprIdx[port_sel[p]] == '0));
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr   <= '0;
      wait_cnt <= '0;
    end else if (!i_stall) begin
      if (n_cnt != '0)
        rr_ptr <= PTR_W'(wrap_add(32'(n_last), 1, REQ_NUM));
      for (int i = 0; i < REQ_NUM; i++) begin
        if (!i_req_vld[i] || gnt_raw[i])
          wait_cnt[i] <= '0;
        else if (wait_cnt[i] != WC_W'(STARVE_LIMIT))
          wait_cnt[i] <= wait_cnt[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_wr_vld    <= '0;
      o_wr_iprIdx <= '0;
      o_wr_data   <= '0;
    end else begin
      o_wr_vld <= i_stall ? '0 : wr_en;
      // Idle ports keep their last idx/data to avoid needless toggling.
      for (int p = 0; p < WPORT_NUM; p++) begin
        if (port_vld[p] && !i_stall) begin
          o_wr_iprIdx[p] <= i_req_iprIdx[port_sel[p]];
          o_wr_data[p]   <= i_req_data[port_sel[p]];
        end
      end
    end
  end

`ifdef IPRF_WB_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      o_perf_conflict_cnt <= '0;
      o_perf_starve_cnt   <= '0;
    end else if (!i_stall) begin
      if ($countones(i_req_vld) > WPORT_NUM)
        o_perf_conflict_cnt <= o_perf_conflict_cnt + 32'd1;
      o_perf_starve_cnt <= o_perf_starve_cnt + 32'(s_cnt);
    end
  end
`endif

`ifndef SYNTHESIS
  // Rename guarantees unique nonzero destinations among live requests.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < REQ_NUM; i++)
        for (int j = i + 1; j < REQ_NUM; j++)
          assert (!(i_req_vld[i] && i_req_vld[j] &&
                    (i_req_iprIdx[i] == i_req_iprIdx[j]) && (i_req_iprIdx[i] != '0)));
    end
  end
`endif
endmodule

// File: tb/tb_iprf_wb_arbiter.sv
module tb_iprf_wb_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic stall = 1'b0;
  logic [7:0]        vld = '0;
  logic [7:0][6:0]   ridx = '0;
  logic [7:0][63:0]  rdata = '0;
  logic [7:0]        gnt;
  logic [5:0]        wr_vld;
  logic [5:0][6:0]   wr_idx;
  logic [5:0][63:0]  wr_data;

  // single-port instance used to reach the starvation path
  logic              stall1 = 1'b0;
  logic [7:0]        vld1 = '0;
  logic [7:0][6:0]   ridx1 = '0;
  logic [7:0][63:0]  rdata1 = '0;
  logic [7:0]        gnt1;
  logic [0:0]        wr1_vld;
  logic [0:0][6:0]   wr1_idx;
  logic [0:0][63:0]  wr1_data;

  iprf_wb_arbiter #(.REQ_NUM(8), .WPORT_NUM(6), .IDX_W(7), .DATA_W(64)) dut (
    .clk(clk), .rst(rst), .i_stall(stall), .i_req_vld(vld), .i_req_iprIdx(ridx),
    .i_req_data(rdata), .o_req_gnt(gnt), .o_wr_vld(wr_vld), .o_wr_iprIdx(wr_idx),
    .o_wr_data(wr_data)
  );

  iprf_wb_arbiter #(.REQ_NUM(8), .WPORT_NUM(1), .IDX_W(7), .DATA_W(64)) dut1 (
    .clk(clk), .rst(rst), .i_stall(stall1), .i_req_vld(vld1), .i_req_iprIdx(ridx1),
    .i_req_data(rdata1), .o_req_gnt(gnt1), .o_wr_vld(wr1_vld), .o_wr_iprIdx(wr1_idx),
    .o_wr_data(wr1_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    int               due;
    logic [5:0]       vld;
    logic [5:0][6:0]  idx;
    logic [5:0][63:0] data;
  } exp_t;
  exp_t q[$];

  int vecs = 0, errs = 0, cyc = 0, serial = 0;

  always @(posedge clk) cyc++;

  // Monitor: pops one expectation whenever the write ports present data.
  always @(negedge clk) begin : mon
    exp_t e;
    logic ok;
    while (q.size() > 0 && q[0].due < cyc) begin
      vecs++; errs++;
      $display("FAIL wr_missing due=%0d now=%0d got_vld=%h req_vld=%h", q[0].due, cyc, wr_vld, q[0].vld);
      void'(q.pop_front());
    end
    if (wr_vld != '0) begin
      vecs++;
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        ok = (wr_vld == e.vld);
        for (int p = 0; p < 6; p++)
          if (e.vld[p] && (wr_idx[p] != e.idx[p] || wr_data[p] != e.data[p])) ok = 1'b0;
        if (!ok) begin
          errs++;
          $display("FAIL wr_port cyc=%0d got vld=%h idx=%h data0=%h req vld=%h idx=%h data0=%h",
                   cyc, wr_vld, wr_idx, wr_data[0], e.vld, e.idx, e.data[0]);
        end
      end else begin
        errs++;
        $display("FAIL wr_unexpected cyc=%0d got vld=%h req vld=0", cyc, wr_vld);
      end
    end
  end

  task automatic set_req(input int r, input logic [6:0] idx);
    serial++;
    ridx[r]  = idx;
    rdata[r] = {16'hCAFE, 8'(r), 8'(serial), 25'b0, idx};
  endtask

  task automatic refresh(input int r);
    set_req(r, 7'(r * 16 + (serial % 15) + 1));
  endtask

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] req);
    vecs++;
    if (got !== req) begin
      errs++;
      $display("FAIL %s cyc=%0d got=%h req=%h", name, cyc, got, req);
    end
  endtask

  // One arbitration cycle. ord holds the expected requester per port,
  // port 0 in the low nibble, F = port unused.
  task automatic step(input logic st, input logic [7:0] v, input logic [23:0] ord);
    logic [7:0] eg;
    exp_t e;
    int r;
    stall = st; vld = v;
    #1;
    eg = '0; e.due = cyc + 1; e.vld = '0; e.idx = '0; e.data = '0;
    for (int p = 0; p < 6; p++) begin
      r = int'(ord[p*4 +: 4]);
      if (r != 15) begin
        eg[r]     = 1'b1;
        e.idx[p]  = ridx[r];
        e.data[p] = rdata[r];
        e.vld[p]  = (ridx[r] != '0);
      end
    end
    check("gnt", 64'(gnt), 64'(eg));
    if (e.vld != '0) q.push_back(e);
    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) if (eg[i]) refresh(i);
  endtask

  initial begin
    int exp1[7] = '{0, 1, 2, 3, 4, 0, 1};
    #2 rst = 1'b0;
    vld = 8'hFF;
    #1;
    check("rst_gnt", 64'(gnt), 64'h0);
    check("rst_wr_vld", 64'(wr_vld), 64'h0);
    check("rst_wr_idx", 64'(wr_idx), 64'h0);
    check("rst_wr_data0", wr_data[0], 64'h0);
    vld = '0;
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #1;

    // six requests idx 1..6 on six ports
    for (int r = 0; r < 6; r++) set_req(r, 7'(r + 1));
    step(1'b0, 8'h3F, 24'h543210);
    for (int r = 0; r < 8; r++) refresh(r);
    step(1'b0, 8'hFF, 24'h321076);   // resumes from rr_ptr=6
    step(1'b0, 8'hFF, 24'h107654);   // rr_ptr=4
    // stall: nothing accepted, nothing written, pointer frozen at 2
    step(1'b1, 8'hFF, 24'hFFFFFF);
    step(1'b1, 8'hFF, 24'hFFFFFF);
    step(1'b1, 8'hFF, 24'hFFFFFF);
    check("stall_wr_vld", 64'(wr_vld), 64'h0);
    step(1'b0, 8'hFF, 24'h765432);
    step(1'b0, 8'hFF, 24'h543210);   // rr_ptr=0 after previous
    // zero register beside idx 9, rr_ptr=6 so scan reaches 0 before 1
    set_req(0, 7'd0); set_req(1, 7'd9);
    step(1'b0, 8'h03, 24'hFFFF10);
    set_req(0, 7'd0);
    step(1'b0, 8'h01, 24'hFFFFF0);   // granted, but no write appears
    for (int r = 0; r < 8; r++) refresh(r);
    step(1'b0, 8'hFF, 24'h654321);
    step(1'b0, 8'hFF, 24'h432107);

    // reset in the middle of a full-width burst
    vld = '0;
    #1;
    check("burst_wr_vld", 64'(wr_vld), 64'h3F);
    rst = 1'b0;
    #1;
    check("async_rst_vld", 64'(wr_vld), 64'h0);
    check("async_rst_idx", 64'(wr_idx), 64'h0);
    q.delete();
    vld = 8'hFF;
    #1;
    check("rst_gnt_mid", 64'(gnt), 64'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    for (int r = 0; r < 8; r++) refresh(r);
    step(1'b0, 8'hFF, 24'h543210);
    step(1'b0, 8'hFF, 24'h321076);
    vld = '0;

    // single port: after four cycles everyone not served is starved, and
    // the starved pass then picks the lowest index rather than rr order
    for (int r = 0; r < 8; r++) begin
      ridx1[r]  = 7'(r + 1);
      rdata1[r] = {32'hB0B0_0000, 24'h0, 8'(r)};
    end
    vld1 = 8'hFF;
    for (int c = 0; c < 7; c++) begin
      #1;
      check("gnt1", 64'(gnt1), 64'(8'(1) << exp1[c]));
      if (c > 0) begin
        check("wr1_vld", 64'(wr1_vld), 64'h1);
        check("wr1_idx", 64'(wr1_idx[0]), 64'(exp1[c-1] + 1));
        check("wr1_data", wr1_data[0], {32'hB0B0_0000, 24'h0, 8'(exp1[c-1])});
      end
      @(posedge clk); #1;
    end
    vld1 = '0;

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", 64'(q.size()), 64'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
